unidade_controle_rodadas: RTL and testbench
===========================================

UNIDADE_CONTROLE_RODADAS -- requirements
Module: unidade_controle_rodadas

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 3000, giving the maximum clock cycles allowed per move (3 s at 1 kHz).
REQ-002 The block SHALL have these ports, clock and reset first:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- jogar  input  1  start/restart request, level.
- jogada  input  1  one-cycle pulse: a button press was detected.
- igualJ  input  1  pressed button equals memory word.
- igualL  input  1  move address equals round limit.
- fimL  input  1  round limit equals last address (15).
- zeraE  output  1  clear address counter.
- contaE  output  1  increment address counter.
- zeraL  output  1  clear limit counter.
- contaL  output  1  increment limit counter.
- zeraR  output  1  clear move register.
- registraR  output  1  load move register.
- pronto  output  1  game finished.
- ganhou  output  1  game won.
- perdeu  output  1  game lost (error or timeout).
- db_timeout  output  1  loss was caused by timeout.
- db_estado  output  4  current state code.

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL be decoded from the current state only.
REQ-004 States and codes SHALL be: INICIAL 0, PREPARA 1, INICIO_RODADA 2, ESPERA 3, REGISTRA 4, COMPARA 5, PROX_JOGADA 6, PROX_RODADA 7, FIM_ACERTO A, FIM_TIMEOUT D, FIM_ERRO E; db_estado SHALL equal the code.
REQ-005 INICIAL SHALL go to PREPARA when jogar=1; otherwise it SHALL stay in INICIAL.
REQ-006 PREPARA SHALL assert zeraE, zeraL and zeraR, then go to INICIO_RODADA.
REQ-007 INICIO_RODADA SHALL assert zeraE, then go to ESPERA.
REQ-008 ESPERA SHALL go to REGISTRA on jogada=1, else to FIM_TIMEOUT when the timer reaches TIMEOUT_CYCLES-1, else stay in ESPERA.
REQ-009 If jogada and timeout occur in the same cycle, jogada SHALL win.
REQ-010 REGISTRA SHALL assert registraR, then go to COMPARA.
REQ-011 COMPARA SHALL branch by priority:
- igualJ=0 -> FIM_ERRO;
- igualL&fimL -> FIM_ACERTO;
- igualL -> PROX_RODADA;
- otherwise -> PROX_JOGADA.
REQ-012 PROX_JOGADA SHALL assert contaE, then go to ESPERA.
REQ-013 PROX_RODADA SHALL assert contaL, then go to INICIO_RODADA.
REQ-014 All three final states SHALL assert pronto.
- FIM_ACERTO SHALL also assert ganhou.
- FIM_ERRO and FIM_TIMEOUT SHALL also assert perdeu.
- FIM_TIMEOUT SHALL also assert db_timeout.
REQ-015 A final state SHALL go to PREPARA on jogar=1, else hold; ganhou, perdeu and db_timeout SHALL drop on leaving it.
REQ-016 jogar SHALL be ignored in all non-final states except INICIAL.
REQ-017 The timer SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide, count only in ESPERA, clear in every other state, and never wrap.
REQ-018 Every datapath control output SHALL be high for exactly one cycle per state visit.

Reset
REQ-019 reset=0 SHALL asynchronously force INICIAL, clear the timer, and drive all outputs to 0, including db_estado=0.
REQ-020 Reset asserted mid-round SHALL abort the game; no further datapath pulses SHALL occur until jogar is seen after reset is released.

Configuration
REQ-021 With TIMEOUT_EN defined, the timer and the FIM_TIMEOUT path SHALL be active.
- Without it, the timer logic SHALL be omitted, ESPERA SHALL wait indefinitely, and db_timeout SHALL be tied to 0.

Structure
REQ-022 State codes and the TIMEOUT_CYCLES default SHALL live in shared package controle_pkg.
REQ-023 The timer SHALL be the sub-module contador_timeout, with ports clock, reset, zera, conta, fim.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, jogar=1 for 5 cycles -> states 0->1->2->3; zeraE/zeraL/zeraR each pulse once; db_estado=3.
- Round 1: jogada with igualJ=1, igualL=1, fimL=0 -> 4,5,7,2,3; contaL pulses once.
- Round 3, move 2: igualJ=0 -> FIM_ERRO; pronto=1, perdeu=1, db_estado=E.
- 16 rounds all correct, fimL=1 on the last compare -> FIM_ACERTO; ganhou=1; then jogar -> PREPARA with ganhou=0.
- TIMEOUT_EN defined, no jogada for 4000 cycles in ESPERA -> FIM_TIMEOUT exactly 3000 cycles after entering ESPERA; db_timeout=1. Without TIMEOUT_EN -> stays at 3.
- reset=0 asynchronously while in COMPARA -> db_estado=0 and all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared definitions for the round controller of the memory game:
// state encoding, default move time budget and timer width helper.
// Optional feature macro: TIMEOUT_EN (enables the per-move timeout path).
package controle_pkg;

    // Default clock cycles allowed per move (3 s at a 1 kHz clock).
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 3000;

    // State codes double as the debug code shown on db_estado.
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

    // Timer width: ceil(log2(n)), never below one bit.
    function automatic int unsigned largura_timer(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-move timer: counts while 'conta' is high, clears on 'zera',
// saturates at TIMEOUT_CYCLES-1 and flags 'fim' while it sits there.
module contador_timeout
    import controle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int unsigned LARGURA = largura_timer(TIMEOUT_CYCLES);
    localparam logic [LARGURA-1:0] LIMITE = LARGURA'(TIMEOUT_CYCLES - 1);

    logic [LARGURA-1:0] r_contagem;

    // Cycle counter: clear, count, or hold once the limit is reached.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state is always written with <= so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta && (r_contagem != LIMITE)) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign fim = (r_contagem == LIMITE);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round controller of the memory game: Moore FSM sequencing rounds and
// moves, driving the address/limit counters and the move register.
// Optional feature macro: TIMEOUT_EN (per-move timeout to FIM_TIMEOUT).
module unidade_controle_rodadas
    import controle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada,
    input  logic       igualJ,
    input  logic       igualL,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_fim;

`ifdef TIMEOUT_EN
    logic w_zera_timer;
    logic w_conta_timer;

    // Timer runs only while waiting for a move and restarts everywhere else.
    assign w_conta_timer = (r_estado == ESPERA);
    assign w_zera_timer  = (r_estado != ESPERA);

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .zera (w_zera_timer),
        .conta(w_conta_timer),
        .fim  (w_fim)
    );
`else
    // Without the timeout feature a move may take arbitrarily long.
    assign w_fim = 1'b0;
`endif

    // State register; reset aborts any game in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic and Moore output decode from the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no
        // path through the case can leave one unassigned (no latches).
        w_proximo  = r_estado;
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraL      = 1'b0;
        contaL     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;

        unique case (r_estado)
            INICIAL: begin
                if (jogar) w_proximo = PREPARA;
            end
            PREPARA: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                w_proximo = INICIO_RODADA;
            end
            INICIO_RODADA: begin
                zeraE     = 1'b1;
                w_proximo = ESPERA;
            end
            ESPERA: begin
                // A press seen on the last allowed cycle still counts.
                if (jogada)     w_proximo = REGISTRA;
                else if (w_fim) w_proximo = FIM_TIMEOUT;
            end
            REGISTRA: begin
                registraR = 1'b1;
                w_proximo = COMPARA;
            end
            COMPARA: begin
                if (!igualJ)             w_proximo = FIM_ERRO;
                else if (igualL && fimL) w_proximo = FIM_ACERTO;
                else if (igualL)         w_proximo = PROX_RODADA;
                else                     w_proximo = PROX_JOGADA;
            end
            PROX_JOGADA: begin
                contaE    = 1'b1;
                w_proximo = ESPERA;
            end
            PROX_RODADA: begin
                contaL    = 1'b1;
                w_proximo = INICIO_RODADA;
            end
            FIM_ACERTO: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar) w_proximo = PREPARA;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar) w_proximo = PREPARA;
            end
            FIM_TIMEOUT: begin
                pronto = 1'b1;
                perdeu = 1'b1;
`ifdef TIMEOUT_EN
                db_timeout = 1'b1;
`endif
                if (jogar) w_proximo = PREPARA;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

    assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for unidade_controle_rodadas: reset, rounds, error,
// full win, timeout (behaviour depends on TIMEOUT_EN) and async reset.
module tb_unidade_controle_rodadas;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic       jogada;
    logic       igualJ;
    logic       igualL;
    logic       fimL;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Cumulative monitor of datapath pulses: cycles high and rising edges.
    // Index: 0 zeraE, 1 contaE, 2 zeraL, 3 contaL, 4 zeraR, 5 registraR.
    int         hi   [6];
    int         rise [6];
    logic [5:0] dp_prev = '0;
    logic [5:0] dp;

    assign dp = {registraR, zeraR, contaL, zeraL, contaE, zeraE};

    unidade_controle_rodadas dut (
        .clock     (clock),
        .reset     (reset),
        .jogar     (jogar),
        .jogada    (jogada),
        .igualJ    (igualJ),
        .igualL    (igualL),
        .fimL      (fimL),
        .zeraE     (zeraE),
        .contaE    (contaE),
        .zeraL     (zeraL),
        .contaL    (contaL),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .db_timeout(db_timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse monitor sampled on the falling edge, away from state updates.
    always @(negedge clock) begin
        for (int i = 0; i < 6; i++) begin
            if (dp[i]) hi[i] = hi[i] + 1;
            if (dp[i] && !dp_prev[i]) rise[i] = rise[i] + 1;
        end
        dp_prev = dp;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] outs();
        return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                pronto, ganhou, perdeu, db_timeout};
    endfunction

    // One move from ESPERA: press, register, compare; checks the branch.
    task automatic move(input logic ij, input logic il, input logic fl,
                        input logic [3:0] exp_next, input string tag);
        jogada = 1'b1; igualJ = ij; igualL = il; fimL = fl;
        tick();
        jogada = 1'b0;
        check({tag, " registra"}, db_estado, 4'h4);
        check({tag, " registraR"}, registraR, 1'b1);
        tick();
        check({tag, " compara"}, db_estado, 4'h5);
        tick();
        check({tag, " branch"}, db_estado, exp_next);
    endtask

    int       snap [6];
    int       sum0;
    int       sum1;
    int       k;
    logic     il;
    logic     fl;
    logic [3:0] exp_st;

    initial begin
        reset = 1'b0; jogar = 1'b0; jogada = 1'b0;
        igualJ = 1'b0; igualL = 1'b0; fimL = 1'b0;

        // Reset state
        #12;
        check("reset estado", db_estado, 4'h0);
        check("reset outs", outs(), 10'h0);
        tick();
        reset = 1'b1;
        tick();
        check("idle estado", db_estado, 4'h0);

        // Start: jogar held 5 cycles, ignored once past INICIAL
        for (int i = 0; i < 6; i++) snap[i] = hi[i];
        jogar = 1'b1;
        tick(); check("start 1", db_estado, 4'h1);
        tick(); check("start 2", db_estado, 4'h2);
        tick(); check("start 3", db_estado, 4'h3);
        tick(); check("start 3b", db_estado, 4'h3);
        tick(); check("start 3c", db_estado, 4'h3);
        jogar = 1'b0;
        check("zeraE one pulse", rise[0], 1);
        check("zeraE two cycles", hi[0] - snap[0], 2);
        check("zeraL one pulse", rise[2], 1);
        check("zeraL one cycle", hi[2] - snap[2], 1);
        check("zeraR one pulse", rise[4], 1);
        check("zeraR one cycle", hi[4] - snap[4], 1);

        // Round 1: single move closes the round
        snap[3] = hi[3];
        move(1'b1, 1'b1, 1'b0, 4'h7, "r1");
        check("r1 contaL", contaL, 1'b1);
        tick(); check("r1 inicio", db_estado, 4'h2);
        tick(); check("r1 espera", db_estado, 4'h3);
        check("r1 contaL count", hi[3] - snap[3], 1);

        // Round 2: two moves
        move(1'b1, 1'b0, 1'b0, 4'h6, "r2m1");
        check("r2m1 contaE", contaE, 1'b1);
        tick(); check("r2m1 espera", db_estado, 4'h3);
        move(1'b1, 1'b1, 1'b0, 4'h7, "r2m2");
        tick(); check("r2 inicio", db_estado, 4'h2);
        tick(); check("r2 espera", db_estado, 4'h3);

        // Round 3: second move wrong -> FIM_ERRO
        move(1'b1, 1'b0, 1'b0, 4'h6, "r3m1");
        tick(); check("r3m1 espera", db_estado, 4'h3);
        move(1'b0, 1'b0, 1'b0, 4'hE, "r3m2");
        check("erro pronto", pronto, 1'b1);
        check("erro perdeu", perdeu, 1'b1);
        check("erro ganhou", ganhou, 1'b0);
        check("erro db_timeout", db_timeout, 1'b0);
        tick(); check("erro hold", db_estado, 4'hE);
        jogar = 1'b1;
        tick(); jogar = 1'b0;
        check("erro restart", db_estado, 4'h1);
        check("erro perdeu drop", perdeu, 1'b0);

        // 16 rounds all correct -> FIM_ACERTO
        tick(); check("win inicio", db_estado, 4'h2);
        tick(); check("win espera", db_estado, 4'h3);
        for (int r = 0; r < 16; r++) begin
            for (int m = 0; m <= r; m++) begin
                il = (m == r);
                fl = (r == 15);
                exp_st = (il && fl) ? 4'hA : (il ? 4'h7 : 4'h6);
                move(1'b1, il, fl, exp_st, "win");
                if (exp_st == 4'h6) begin
                    tick(); check("win prox espera", db_estado, 4'h3);
                end else if (exp_st == 4'h7) begin
                    tick(); check("win rodada inicio", db_estado, 4'h2);
                    tick(); check("win rodada espera", db_estado, 4'h3);
                end
            end
        end
        check("win estado", db_estado, 4'hA);
        check("win ganhou", ganhou, 1'b1);
        check("win pronto", pronto, 1'b1);
        check("win perdeu", perdeu, 1'b0);
        tick(); check("win hold", db_estado, 4'hA);
        jogar = 1'b1;
        tick(); jogar = 1'b0;
        check("win restart", db_estado, 4'h1);
        check("win ganhou drop", ganhou, 1'b0);

        // Timeout: no jogada while in ESPERA
        tick(); check("to inicio", db_estado, 4'h2);
        tick(); check("to espera", db_estado, 4'h3);
`ifdef TIMEOUT_EN
        k = 0;
        while (db_estado != 4'hD && k < 4000) begin
            tick();
            k++;
        end
        check("timeout latency", k, 3000);
        check("timeout estado", db_estado, 4'hD);
        check("timeout db_timeout", db_timeout, 1'b1);
        check("timeout perdeu", perdeu, 1'b1);
        check("timeout pronto", pronto, 1'b1);
        jogar = 1'b1;
        tick(); jogar = 1'b0;
        check("timeout restart", db_estado, 4'h1);
        check("timeout flag drop", db_timeout, 1'b0);
        tick(); tick();
        check("to2 espera", db_estado, 4'h3);
`else
        repeat (4000) tick();
        check("no timeout estado", db_estado, 4'h3);
        check("no timeout flag", db_timeout, 1'b0);
`endif

        // Asynchronous reset while in COMPARA
        jogada = 1'b1; igualJ = 1'b1; igualL = 1'b0; fimL = 1'b0;
        tick(); jogada = 1'b0;
        check("ar registra", db_estado, 4'h4);
        tick();
        check("ar compara", db_estado, 4'h5);
        #2 reset = 1'b0;
        #1;
        check("ar estado", db_estado, 4'h0);
        check("ar outs", outs(), 10'h0);
        tick();
        reset = 1'b1;
        sum0 = 0;
        for (int i = 0; i < 6; i++) sum0 += hi[i];
        repeat (5) tick();
        sum1 = 0;
        for (int i = 0; i < 6; i++) sum1 += hi[i];
        check("ar idle", db_estado, 4'h0);
        check("ar no pulses", sum1 - sum0, 0);
        jogar = 1'b1;
        tick(); jogar = 1'b0;
        check("ar restart", db_estado, 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
